// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command sequencer.
// Optional build macro: SPI_CMD_PARITY_EN (even parity over each SPI word).
package spi_cmd_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_OPC_W = 4;
  localparam int DEF_ERR_W = 8;

  typedef enum logic [3:0] {
    OPC_NOP      = 4'h0,
    OPC_SETPOINT = 4'h1,
    OPC_KP       = 4'h2,
    OPC_LIMIT    = 4'h3,
    OPC_ENABLE   = 4'h4,
    OPC_COMMIT   = 4'hF
  } opc_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DECODE     = 2'd1,
    ST_WAIT_READY = 2'd2,
    ST_COMMIT     = 2'd3
  } state_e;

  // Reset fill bits, replicated to the configured payload width.
  localparam logic RST_SETPOINT_BIT = 1'b0;
  localparam logic RST_KP_BIT       = 1'b0;
  localparam logic RST_LIMIT_BIT    = 1'b1;
  localparam logic RST_ENABLE       = 1'b0;

  // Zero-extension does not change parity, so any word up to 32 bits fits.
  function automatic logic even_parity_ok(input logic [31:0] word);
    return ((^word) == 1'b0);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
// The pulse appears three sys_clk edges after the asynchronous input rises.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, prev_q, pulse_q;

  // Synchroniser chain, edge history and registered pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/spi_cmd_controller.sv
// SPI command sequencer: shadow register writes, gated atomic COMMIT to live outputs.
// Optional build macro: SPI_CMD_PARITY_EN (even-parity check, payload bit 0 carries parity).
module spi_cmd_controller
  import spi_cmd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int OPC_W  = DEF_OPC_W,
  parameter int DATA_W = WIDTH - OPC_W,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic              sys_clk,
  input  logic              sys_reset_n,
  input  logic [WIDTH-1:0]  mosi_buffer,
  input  logic              mosi_buffer_valid,
  input  logic              ctrl_ready,
  output logic [DATA_W-1:0] setpoint,
  output logic [DATA_W-1:0] kp,
  output logic [DATA_W-1:0] out_limit,
  output logic              ctrl_enable,
  output logic              cfg_update,
  output logic              busy,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [DATA_W-1:0] SP_RST    = {DATA_W{RST_SETPOINT_BIT}};
  localparam logic [DATA_W-1:0] KP_RST    = {DATA_W{RST_KP_BIT}};
  localparam logic [DATA_W-1:0] LIMIT_RST = {DATA_W{RST_LIMIT_BIT}};
  localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

  logic              word_strobe_s;
  state_e            state_q, state_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic [DATA_W-1:0] sh_sp_q, sh_sp_d, sh_kp_q, sh_kp_d, sh_lim_q, sh_lim_d;
  logic              sh_en_q, sh_en_d;
  logic [DATA_W-1:0] lv_sp_q, lv_sp_d, lv_kp_q, lv_kp_d, lv_lim_q, lv_lim_d;
  logic              lv_en_q, lv_en_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              cfg_update_q, cfg_update_d;
  logic              busy_q, busy_d;

  opc_e              opc_s;
  logic [DATA_W-1:0] payload_s;
  logic              en_bit_s, parity_ok_s, bad_opc_s, commit_s, err_inc_s, decode_ok_s;

  sync_edge_detect u_valid_sync (
    .clk_i   (sys_clk),
    .rst_ni  (sys_reset_n),
    .async_i (mosi_buffer_valid),
    .pulse_o (word_strobe_s)
  );

  // Field extraction and validity of the captured word.
  always_comb begin
    opc_s = opc_e'(word_q[WIDTH-1 -: OPC_W]);
`ifdef SPI_CMD_PARITY_EN
    parity_ok_s = even_parity_ok(32'(word_q));
    payload_s   = {word_q[DATA_W-1:1], 1'b0};
    en_bit_s    = payload_s[1];
`else
    parity_ok_s = 1'b1;
    payload_s   = word_q[DATA_W-1:0];
    en_bit_s    = payload_s[0];
`endif
    case (opc_s)
      OPC_NOP, OPC_SETPOINT, OPC_KP, OPC_LIMIT, OPC_ENABLE, OPC_COMMIT: bad_opc_s = 1'b0;
      default: bad_opc_s = 1'b1;
    endcase
  end

  // Next-state logic for the sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (word_strobe_s) state_d = ST_DECODE;
        else               state_d = ST_IDLE;
      end
      ST_DECODE: begin
        if (parity_ok_s && (opc_s == OPC_COMMIT)) state_d = ST_WAIT_READY;
        else                                      state_d = ST_IDLE;
      end
      ST_WAIT_READY: begin
        if (ctrl_ready) state_d = ST_COMMIT;
        else            state_d = ST_WAIT_READY;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: capture, shadow writes, live commit, error counting.
  always_comb begin
    word_d   = word_q;
    sh_sp_d  = sh_sp_q;
    sh_kp_d  = sh_kp_q;
    sh_lim_d = sh_lim_q;
    sh_en_d  = sh_en_q;
    lv_sp_d  = lv_sp_q;
    lv_kp_d  = lv_kp_q;
    lv_lim_d = lv_lim_q;
    lv_en_d  = lv_en_q;
    err_d    = err_q;

    decode_ok_s = (state_q == ST_DECODE) && parity_ok_s;
    // Live registers load on the edge entering COMMIT so they are valid with the pulse.
    commit_s    = (state_q == ST_WAIT_READY) && ctrl_ready;
    // An overrun and a bad word in the same cycle collapse into one increment.
    err_inc_s   = (word_strobe_s && (state_q != ST_IDLE)) ||
                  ((state_q == ST_DECODE) && (!parity_ok_s || bad_opc_s));

    if ((state_q == ST_IDLE) && word_strobe_s) word_d = mosi_buffer;
    else                                       word_d = word_q;

    if (decode_ok_s) begin
      case (opc_s)
        OPC_SETPOINT: sh_sp_d  = payload_s;
        OPC_KP:       sh_kp_d  = payload_s;
        OPC_LIMIT:    sh_lim_d = payload_s;
        OPC_ENABLE:   sh_en_d  = en_bit_s;
        default:      sh_sp_d  = sh_sp_q;
      endcase
    end else begin
      sh_sp_d = sh_sp_q;
    end

    if (commit_s) begin
      lv_sp_d  = sh_sp_q;
      lv_kp_d  = sh_kp_q;
      lv_lim_d = sh_lim_q;
      lv_en_d  = sh_en_q;
    end else begin
      lv_sp_d = lv_sp_q;
    end

    if (err_inc_s && (err_q != ERR_MAX)) err_d = err_q + ERR_W'(1);
    else                                 err_d = err_q;

    cfg_update_d = commit_s;
    busy_d       = (state_d != ST_IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      sh_sp_q      <= SP_RST;
      sh_kp_q      <= KP_RST;
      sh_lim_q     <= LIMIT_RST;
      sh_en_q      <= RST_ENABLE;
      lv_sp_q      <= SP_RST;
      lv_kp_q      <= KP_RST;
      lv_lim_q     <= LIMIT_RST;
      lv_en_q      <= RST_ENABLE;
      err_q        <= '0;
      cfg_update_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      sh_sp_q      <= sh_sp_d;
      sh_kp_q      <= sh_kp_d;
      sh_lim_q     <= sh_lim_d;
      sh_en_q      <= sh_en_d;
      lv_sp_q      <= lv_sp_d;
      lv_kp_q      <= lv_kp_d;
      lv_lim_q     <= lv_lim_d;
      lv_en_q      <= lv_en_d;
      err_q        <= err_d;
      cfg_update_q <= cfg_update_d;
      busy_q       <= busy_d;
    end
  end

  assign setpoint    = lv_sp_q;
  assign kp          = lv_kp_q;
  assign out_limit   = lv_lim_q;
  assign ctrl_enable = lv_en_q;
  assign cfg_update  = cfg_update_q;
  assign busy        = busy_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Self-checking bench for spi_cmd_controller: directed scenarios plus random words
// checked against a transaction-level model of shadow/live registers and error count.
module tb_spi_cmd_controller;

  logic        sys_clk = 1'b0;
  logic        sys_reset_n = 1'b0;
  logic [15:0] mosi_buffer = 16'h0000;
  logic        mosi_buffer_valid = 1'b0;
  logic        ctrl_ready = 1'b0;
  logic [11:0] setpoint, kp, out_limit;
  logic        ctrl_enable, cfg_update, busy;
  logic [7:0]  err_count;

  spi_cmd_controller dut (
    .sys_clk           (sys_clk),
    .sys_reset_n       (sys_reset_n),
    .mosi_buffer       (mosi_buffer),
    .mosi_buffer_valid (mosi_buffer_valid),
    .ctrl_ready        (ctrl_ready),
    .setpoint          (setpoint),
    .kp                (kp),
    .out_limit         (out_limit),
    .ctrl_enable       (ctrl_enable),
    .cfg_update        (cfg_update),
    .busy              (busy),
    .err_count         (err_count)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int cfg_seen = 0;
  int last_cfg_cyc = -1;
  always @(negedge sys_clk) begin
    if (cfg_update === 1'b1) begin
      cfg_seen = cfg_seen + 1;
      last_cfg_cyc = cyc;
    end
  end

  int total = 0;
  int bad = 0;
  int raise_cyc = 0;

  // Reference model: shadow and live register sets, pending commit, error count.
  logic [11:0] s_sp, s_kp, s_lim, l_sp, l_kp, l_lim;
  logic        s_en, l_en;
  int          m_err, m_cfg;
  bit          m_pending;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    s_sp = 12'h000; s_kp = 12'h000; s_lim = 12'hFFF; s_en = 1'b0;
    l_sp = 12'h000; l_kp = 12'h000; l_lim = 12'hFFF; l_en = 1'b0;
    m_err = 0;
    m_pending = 1'b0;
  endtask

  task automatic model_err();
    if (m_err < 255) m_err = m_err + 1;
  endtask

  task automatic model_commit();
    l_sp = s_sp; l_kp = s_kp; l_lim = s_lim; l_en = s_en;
    m_cfg = m_cfg + 1;
    m_pending = 1'b0;
  endtask

  task automatic model_word(input logic [15:0] w);
    logic [3:0]  opc;
    logic [11:0] data;
    logic        en;
    opc  = w[15:12];
    data = w[11:0];
    if (m_pending) begin
      model_err();
      return;
    end
`ifdef SPI_CMD_PARITY_EN
    if ((^w) != 1'b0) begin
      model_err();
      return;
    end
    data = {data[11:1], 1'b0};
    en = data[1];
`else
    en = data[0];
`endif
    case (opc)
      4'h0: ;
      4'h1: s_sp = data;
      4'h2: s_kp = data;
      4'h3: s_lim = data;
      4'h4: s_en = en;
      4'hF: begin
        if (ctrl_ready) model_commit();
        else m_pending = 1'b1;
      end
      default: model_err();
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".setpoint"}, 32'(setpoint), 32'(l_sp));
    check({tag, ".kp"}, 32'(kp), 32'(l_kp));
    check({tag, ".out_limit"}, 32'(out_limit), 32'(l_lim));
    check({tag, ".ctrl_enable"}, 32'(ctrl_enable), 32'(l_en));
    check({tag, ".err_count"}, 32'(err_count), 32'(m_err));
    check({tag, ".busy"}, 32'(busy), 32'(m_pending));
    check({tag, ".cfg_pulses"}, 32'(cfg_seen), 32'(m_cfg));
  endtask

  // Raise valid, hold the word until captured, drop valid long enough to re-arm the edge detector.
  task automatic send_word(input logic [15:0] w);
    @(negedge sys_clk);
    mosi_buffer = w;
    mosi_buffer_valid = 1'b1;
    raise_cyc = cyc;
    repeat (4) @(negedge sys_clk);
    mosi_buffer_valid = 1'b0;
    repeat (4) @(negedge sys_clk);
    model_word(w);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_reset_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_reset_n = 1'b1;
    model_reset();
    @(negedge sys_clk);
  endtask

  initial begin
    logic [15:0] w;
    logic [3:0]  opc_pick;
    bit          rdy;
    int          cfg_before;

    m_cfg = 0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    sys_reset_n = 1'b1;
    @(negedge sys_clk);
    check_all("reset");
    check("reset.limit_ones", 32'(out_limit), 32'h0000_0FFF);

    // Shadow writes then commit with the controller ready.
    ctrl_ready = 1'b1;
    send_word(16'h1123);
    send_word(16'h2045);
    check_all("shadow_only");
    send_word(16'hF000);
    check_all("commit");
    check("commit.latency", 32'(last_cfg_cyc), 32'(raise_cyc + 6));
`ifndef SPI_CMD_PARITY_EN
    check("commit.setpoint_lit", 32'(setpoint), 32'h0000_0123);
    check("commit.kp_lit", 32'(kp), 32'h0000_0045);
`endif

    // Commit held off by ctrl_ready, with an overrun word arriving meanwhile.
    ctrl_ready = 1'b0;
    send_word(16'h4001);
    send_word(16'hF000);
    cfg_before = cfg_seen;
    repeat (20) @(negedge sys_clk);
    check_all("gate_wait");
    check("gate_wait.no_pulse", 32'(cfg_seen), 32'(cfg_before));
    send_word(16'h1555);
    check_all("overrun");
    ctrl_ready = 1'b1;
    model_commit();
    @(negedge sys_clk);
    check("gate.cfg_update", 32'(cfg_update), 32'h1);
    check("gate.enable", 32'(ctrl_enable), 32'(l_en));
    @(negedge sys_clk);
    check_all("gate_done");
`ifndef SPI_CMD_PARITY_EN
    check("gate.enable_lit", 32'(ctrl_enable), 32'h1);
    check("gate.setpoint_lit", 32'(setpoint), 32'h0000_0123);
    check("gate.err_lit", 32'(err_count), 32'h1);
`endif

    // Reset while a commit is pending abandons it.
    ctrl_ready = 1'b0;
    send_word(16'h1ABC);
    send_word(16'hF000);
    check_all("pre_reset");
    do_reset();
    check_all("mid_wait_reset");
    ctrl_ready = 1'b1;
    repeat (4) @(negedge sys_clk);
    check_all("post_reset_ready");

    // Invalid opcodes saturate the error counter.
    for (int i = 0; i < 300; i++) send_word(16'h7000);
    check_all("saturate");
    check("saturate.err_lit", 32'(err_count), 32'h0000_00FF);

`ifdef SPI_CMD_PARITY_EN
    do_reset();
    send_word(16'h1123);
    check("parity.bad_err", 32'(err_count), 32'h1);
    send_word(16'h1122);
    send_word(16'hF000);
    check("parity.setpoint", 32'(setpoint), 32'h0000_0122);
    check_all("parity");
`endif

    // Random words with random readiness against the model.
    do_reset();
    for (int i = 0; i < 80; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      @(negedge sys_clk);
      ctrl_ready = rdy;
      if (rdy && m_pending) model_commit();
      case ($urandom_range(0, 6))
        0: opc_pick = 4'h1;
        1: opc_pick = 4'h2;
        2: opc_pick = 4'h3;
        3: opc_pick = 4'h4;
        4: opc_pick = 4'hF;
        5: opc_pick = 4'h0;
        default: opc_pick = 4'($urandom_range(0, 15));
      endcase
      w = {opc_pick, 12'($urandom())};
      if ($urandom_range(0, 3) != 0) w[0] = w[0] ^ (^w);
      send_word(w);
      check_all("random");
    end
    @(negedge sys_clk);
    ctrl_ready = 1'b1;
    if (m_pending) model_commit();
    repeat (4) @(negedge sys_clk);
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
